// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle adder/subtractor that works CHUNK bits per clock,
// LSB chunk first, through a CHUNK-bit slice and a registered carry.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   start           - request, sampled only while idle
//   A, B, CI, FS    - operands, carry in and function select, sampled with start
//   busy, done      - operation in progress / one-cycle result-valid pulse
//   Y, C, V, Z, N   - registered result and flags, held until next completion
module chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic [2:0]       FS,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             C,
  output logic             V,
  output logic             Z,
  output logic             N
);

  localparam int unsigned NCH   = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned SUM_W = CHUNK + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   be_q, be_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               pass_q, pass_d;
  logic               a_msb_q, a_msb_d;
  logic               be_msb_q, be_msb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               c_q, c_d;
  logic               v_q, v_d;
  logic               z_q, z_d;
  logic               n_q, n_d;

  logic [SUM_W-1:0]   sum_c;
  logic [WIDTH-1:0]   res_shift_c;
  logic               last_c;
  logic [WIDTH-1:0]   be_sel_c;
  logic               c0_sel_c;

  // Chunk slice: low CHUNK bits of both shift registers plus the carry.
  assign sum_c = {1'b0, a_q[CHUNK-1:0]} + {1'b0, be_q[CHUNK-1:0]} + SUM_W'(carry_q);

  // New sum chunk enters the result register from the top.
  assign res_shift_c = (res_q >> CHUNK) | (WIDTH'(sum_c[CHUNK-1:0]) << (WIDTH - CHUNK));

  assign last_c = (cnt_q == CNT_W'(NCH - 1));

  // Resolve function select into effective operand and initial carry.
  // Pass mode adds zero with no carry so the datapath reproduces A.
  always_comb begin
    be_sel_c = B;
    c0_sel_c = CI;
    if (FS[2]) begin
      be_sel_c = '0;
      c0_sel_c = 1'b0;
    end else begin
      case (FS[1:0])
        2'b00:   begin be_sel_c = B;   c0_sel_c = CI;   end
        2'b01:   begin be_sel_c = ~B;  c0_sel_c = CI;   end
        2'b10:   begin be_sel_c = '0;  c0_sel_c = 1'b1; end
        default: begin be_sel_c = '1;  c0_sel_c = 1'b0; end
      endcase
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    be_d     = be_q;
    res_d    = res_q;
    carry_d  = carry_q;
    pass_d   = pass_q;
    a_msb_d  = a_msb_q;
    be_msb_d = be_msb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    y_d      = y_q;
    c_d      = c_q;
    v_d      = v_q;
    z_d      = z_q;
    n_d      = n_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          be_d     = be_sel_c;
          carry_d  = c0_sel_c;
          pass_d   = FS[2];
          a_msb_d  = A[WIDTH-1];
          be_msb_d = be_sel_c[WIDTH-1];
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        be_d    = be_q >> CHUNK;
        carry_d = sum_c[CHUNK];
        res_d   = res_shift_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_c) begin
          y_d     = res_shift_c;
          c_d     = sum_c[CHUNK];
          v_d     = !pass_q && (a_msb_q == be_msb_q) && (res_shift_c[WIDTH-1] != a_msb_q);
          z_d     = (res_shift_c == '0);
          n_d     = res_shift_c[WIDTH-1];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      be_q     <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      pass_q   <= 1'b0;
      a_msb_q  <= 1'b0;
      be_msb_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      y_q      <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      be_q     <= be_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      pass_q   <= pass_d;
      a_msb_q  <= a_msb_d;
      be_msb_q <= be_msb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      y_q      <= y_d;
      c_q      <= c_d;
      v_q      <= v_d;
      z_q      <= z_d;
      n_q      <= n_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Y    = y_q;
  assign C    = c_q;
  assign V    = v_q;
  assign Z    = z_q;
  assign N    = n_q;

endmodule

// File: doc/chunk_adder.md
# chunk_adder

Parametrised multi-cycle adder/subtractor for the ALU datapath, succeeding the 8-bit single-cycle ripple adder. Latches operands on a `start` strobe, then processes them CHUNK bits per clock, LSB chunk first, through a CHUNK-bit adder slice and a registered carry. It delivers Y with C/V/Z/N flags and a one-cycle `done` pulse. This trades latency for a short carry chain, so wide datapaths meet timing.

## Interface
- WIDTH, 16: operand/result width; must be ≥ 2.
- CHUNK, 4: bits added per cycle; must divide WIDTH. NCH = WIDTH/CHUNK.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when idle.
- A  in  WIDTH  operand A, sampled with start.
- B  in  WIDTH  operand B, sampled with start.
- CI  in  1  carry in, sampled with start.
- FS  in  3  function select, sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse: result valid.
- Y  out  WIDTH  result, registered, held until next completion.
- C  out  1  carry out of the MSB.
- V  out  1  signed overflow.
- Z  out  1  Y == 0.
- N  out  1  Y[WIDTH-1].

## Operation
- Modes, resolved at start into effective operand Be and carry c0:
  - 000 add: Be=B, c0=CI.
  - 001 sub: Be=~B, c0=CI; caller drives CI=1 for A−B.
  - 010 increment: Be=0, c0=1; CI ignored.
  - 011 decrement: Be=all ones, c0=0; CI ignored.
  - 1xx pass: Y=A, C=0, V=0; still runs the full NCH cycles.
- FSM states:
  - IDLE: busy=0. On start=1, latch A, Be, c0 and mode; clear chunk counter; go to RUN.
  - RUN: busy=1. Each cycle, add the low CHUNK bits of the A and Be shift registers plus the carry register. Shift the sum chunk into the result register from the top. Update the carry register and increment the counter.
  - Exit RUN: after chunk NCH−1, load Y/C/V/Z/N, pulse done, return to IDLE.
- Flag rules:
  - C is the final carry register.
  - V = (A[MSB] == Be[MSB]) && (Y[MSB] != A[MSB]) in modes 000–011; 0 in pass mode.
  - Z and N are computed from the final Y in every mode.
  - All arithmetic is modulo 2^WIDTH.
- Start handling:
  - start while busy=1 is ignored and not queued.
  - start in the same cycle as done is accepted (back-to-back).
  - A/B/CI/FS changes after the start edge do not affect the operation in flight.
- Reset value of every output: busy=0, done=0, Y=0, C=0, V=0, Z=0, N=0; state IDLE; counter and carry cleared.
- Reset mid-operation aborts the operation: no done pulse, outputs go to reset values. Reset wins over a simultaneous start.

## Timing
- Edge 0: start sampled in IDLE. busy=1 from edge 0.
- Edges 1..NCH: one chunk processed per edge.
- Edge NCH: result registers load, busy drops, done=1 for exactly the cycle after edge NCH.
- Latency: start edge to done-high is NCH+1 edges; issue interval is NCH+1 cycles.
- With CHUNK=WIDTH: one RUN cycle, done in the cycle after edge 1.
- Y and the flags change only at the done edge and at reset.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 (done high in the cycle after edge 4, counting the start edge as edge 0) unless noted.
- Add overflow: FS=000, A=0x7FFF, B=0x0001, CI=0 -> Y=0x8000, C=0, V=1, N=1, Z=0.
- Wrap: FS=000, A=0xFFFF, B=0x0001, CI=0 -> Y=0x0000, C=1, V=0, Z=1.
- Subtract: FS=001, A=0x0005, B=0x0005, CI=1 -> Y=0, C=1, V=0, Z=1. Then A=0x0003, B=0x0005 -> Y=0xFFFE, C=0, N=1.
- Start during busy: second start with A=0x1111 at edge 2 is ignored and first result delivered. Start in the done cycle is accepted; its done arrives 5 cycles later.
- Reset at edge 2 of a RUN -> no done; busy and all outputs 0 next cycle. A following add 0x0001+0x0002 returns Y=0x0003.
- Instance WIDTH=8, CHUNK=8: FS=011, A=0x00 -> Y=0xFF, C=0, N=1, done one cycle after RUN. FS=100, A=0x80 -> Y=0x80, C=0, V=0, N=1.
